intrx: RTL and testbench
========================

INTRX -- requirements
Module: intrx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of event/status bits.
REQ-002 SHALL have parameter HOLD_W, default 8, meaning the holdoff counter width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning the reset, which is asynchronous and active-low.
REQ-005 SHALL have port stky  input  WIDTH  meaning the latched event status from the upstream sticky-event register.
REQ-006 SHALL have port upen  input  1  meaning the microprocessor select for this block.
REQ-007 SHALL have port upws  input  1  meaning the write strobe.
REQ-008 SHALL have port uprs  input  1  meaning the read strobe.
REQ-009 SHALL have port upa  input  2  meaning the register address.
REQ-010 SHALL have port updi  input  WIDTH  meaning the write data.
REQ-011 SHALL have port updo  output  WIDTH  meaning the read data.
REQ-012 SHALL have port upack  output  1  meaning the access acknowledge.
REQ-013 SHALL have port irq  output  1  meaning the interrupt to the CPU.

Function
REQ-014 SHALL define wr_en = upen & upws and rd_en = upen & uprs.
REQ-015 SHALL provide address map: 0 = mask (RW, WIDTH bits); 1 = holdoff (RW, low HOLD_W bits, upper read bits 0, HOLD_W <= WIDTH); 2 = pend = stky & mask (RO, writes ignored); 3 = reserved (reads 0, writes ignored).
REQ-016 SHALL update a written register on the clock edge where wr_en is high; the new value is visible to the FSM the following cycle.
REQ-017 SHALL register updo one cycle after rd_en with the addressed value sampled at the rd_en edge, and drive updo to 0 in every cycle not following rd_en.
REQ-018 SHALL register upack = wr_en | rd_en, giving a single-cycle ack per strobe cycle with 1-cycle latency.
REQ-019 SHALL implement FSM states IDLE, ASSERT and HOLD.
REQ-020 IDLE SHALL go to ASSERT when |pend; otherwise it stays in IDLE.
REQ-021 ASSERT SHALL stay while |pend; when pend == 0 it goes to IDLE if holdoff == 0, else to HOLD with cnt loaded = holdoff.
REQ-022 HOLD SHALL decrement cnt each cycle and go to IDLE in the cycle cnt == 1, giving exactly holdoff cycles in HOLD; pend is ignored while in HOLD.
REQ-023 SHALL not restart a count already in progress when holdoff is written during HOLD; the new value applies to the next entry into HOLD.
REQ-024 SHALL drive irq registered, high exactly while the state is ASSERT (level mode).
REQ-025 SHALL treat a mask write clearing all pending bits in ASSERT identically to stky clearing (ASSERT to HOLD/IDLE).
REQ-026 SHALL, when stky and a mask write change in the same cycle, evaluate pend from the registered mask, i.e. the pre-write value.

Reset
REQ-027 SHALL, on rst_n low, asynchronously set mask = 0, holdoff = 0, cnt = 0, state = IDLE, irq = 0, updo = 0 and upack = 0.
REQ-028 SHALL, on reset asserted mid-ASSERT or mid-HOLD, drop irq immediately; after release the FSM starts in IDLE.

Configuration
REQ-029 SHALL use macro INTRX_PULSE_EN: when defined, irq is a single-cycle pulse on each IDLE to ASSERT transition; when undefined, irq is level per REQ-024. The FSM and register map are identical in both builds.

Verification
REQ-030 Bench SHALL cover: reset, then write mask=0x05 at addr0, then stky=0x04 -> irq rises 2 cycles after stky; a read of addr2 returns 0x04 with upack after 1 cycle.
REQ-031 Bench SHALL cover: holdoff=3, stky 0x04 to 0x00 in ASSERT -> irq low for exactly 3 HOLD cycles; stky=0x01 during HOLD -> irq re-asserts only after return to IDLE.
REQ-032 Bench SHALL cover: mask=0x00 written while in ASSERT with stky=0xFF -> irq falls; a read of addr2 returns 0x00.
REQ-033 Bench SHALL cover: rst_n pulsed low mid-HOLD -> irq, updo and upack are 0 asynchronously; a read of addr0 returns 0x00.
REQ-034 Bench SHALL cover: write addr2 with 0xFF, and read addr3 -> no state change, addr3 read returns 0x00, upack asserted for each access.
REQ-035 Bench SHALL cover, with INTRX_PULSE_EN defined: stky held at 0x01 with mask=0x01 -> irq high for exactly one cycle.

Source files
------------

// File: rtl/intrx.sv
// Interrupt controller: masks sticky event status, raises irq, then holds off re-arming for a programmable time.
// Build option INTRX_PULSE_EN: irq pulses once per IDLE->ASSERT entry instead of following the ASSERT level.
module intrx #(
    parameter int WIDTH  = 8,
    parameter int HOLD_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] stky,
    input  logic             upen,
    input  logic             upws,
    input  logic             uprs,
    input  logic [1:0]       upa,
    input  logic [WIDTH-1:0] updi,
    output logic [WIDTH-1:0] updo,
    output logic             upack,
    output logic             irq
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [HOLD_W-1:0] cnt;
    logic [HOLD_W-1:0] cnt_nxt;
    logic [HOLD_W-1:0] holdoff;
    logic [WIDTH-1:0]  mask;
    logic [WIDTH-1:0]  pend;
    logic [WIDTH-1:0]  hold_ext;
    logic [WIDTH-1:0]  rd_val;
    logic              wr_en;
    logic              rd_en;

    assign wr_en = upen & upws;
    assign rd_en = upen & uprs;
    // Registered mask: a same-cycle mask write only affects pend from the next cycle.
    assign pend  = stky & mask;

    always_comb begin
        hold_ext               = '0;
        hold_ext[HOLD_W-1:0]   = holdoff;
    end

    always_comb begin
        rd_val = '0;
        case (upa)
            2'd0:    rd_val = mask;
            2'd1:    rd_val = hold_ext;
            2'd2:    rd_val = pend;
            default: rd_val = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (|pend) state_nxt = ASSERT;
            end
            ASSERT: begin
                if (!(|pend)) begin
                    if (holdoff == '0) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = HOLD;
                        cnt_nxt   = holdoff;
                    end
                end
            end
            HOLD: begin
                // pend is deliberately ignored until the holdoff count expires.
                cnt_nxt = cnt - HOLD_ONE;
                if (cnt == HOLD_ONE) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef INTRX_PULSE_EN
    logic enter_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enter_p <= 1'b0;
            irq     <= 1'b0;
        end else begin
            enter_p <= (state == IDLE) && (state_nxt == ASSERT);
            irq     <= enter_p;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq <= 1'b0;
        else        irq <= (state == ASSERT);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            mask    <= '0;
            holdoff <= '0;
            updo    <= '0;
            upack   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (wr_en) begin
                case (upa)
                    2'd0:    mask    <= updi;
                    2'd1:    holdoff <= updi[HOLD_W-1:0];
                    default: ;
                endcase
            end
            upack <= wr_en | rd_en;
            updo  <= rd_en ? rd_val : '0;
        end
    end

endmodule

// File: tb/tb_intrx.sv
// Randomized and directed bench for intrx against a cycle-level behavioural model.
module tb_intrx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] stky;
    logic       upen, upws, uprs;
    logic [1:0] upa;
    logic [7:0] updi;
    logic [7:0] updo;
    logic       upack;
    logic       irq;

    int checks = 0;
    int errors = 0;

    // Model state: asserted flag plus remaining holdoff cycles (0 means not holding).
    logic [7:0] m_mask;
    int         m_hold;
    bit         m_asserted;
    int         m_hold_left;
    bit         m_enter;
    bit         m_irq;
    logic [7:0] m_updo;
    bit         m_upack;

    always #5 clk = ~clk;

    intrx #(.WIDTH(8), .HOLD_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .stky  (stky),
        .upen  (upen),
        .upws  (upws),
        .uprs  (uprs),
        .upa   (upa),
        .updi  (updi),
        .updo  (updo),
        .upack (upack),
        .irq   (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mask      = '0;
        m_hold      = 0;
        m_asserted  = 0;
        m_hold_left = 0;
        m_enter     = 0;
        m_irq       = 0;
        m_updo      = '0;
        m_upack     = 0;
    endtask

    // Applies one rising edge to the model using the inputs present before it.
    task automatic model_step();
        logic [7:0] pend;
        logic [7:0] rv;
        bit         rd;
        bit         wr;
        pend = stky & m_mask;
        rd   = upen & uprs;
        wr   = upen & upws;
        case (upa)
            2'd0:    rv = m_mask;
            2'd1:    rv = 8'(m_hold);
            2'd2:    rv = pend;
            default: rv = '0;
        endcase
        m_updo  = rd ? rv : 8'h00;
        m_upack = rd | wr;
`ifdef INTRX_PULSE_EN
        m_irq   = m_enter;
`else
        m_irq   = m_asserted;
`endif
        m_enter = 0;
        if (m_hold_left > 0) begin
            m_hold_left--;
        end else if (m_asserted) begin
            if (pend == 0) begin
                m_asserted  = 0;
                m_hold_left = m_hold;
            end
        end else if (pend != 0) begin
            m_asserted = 1;
            m_enter    = 1;
        end
        if (wr) begin
            if (upa == 2'd0) m_mask = updi;
            if (upa == 2'd1) m_hold = int'(updi);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("irq", irq, m_irq);
        chk("updo", updo, m_updo);
        chk("upack", upack, m_upack);
    endtask

    task automatic access(input bit wr, input logic [1:0] a, input logic [7:0] d);
        upen = 1'b1;
        upws = wr;
        uprs = !wr;
        upa  = a;
        updi = d;
        cycle();
        upen = 1'b0;
        upws = 1'b0;
        uprs = 1'b0;
        updi = '0;
    endtask

    task automatic async_reset();
        #3 rst_n = 1'b0;
        #1;
        chk("rst_irq", irq, 0);
        chk("rst_updo", updo, 0);
        chk("rst_upack", upack, 0);
        model_reset();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int n;
        stky  = '0;
        upen  = 1'b0;
        upws  = 1'b0;
        uprs  = 1'b0;
        upa   = '0;
        updi  = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("init_irq", irq, 0);
        chk("init_updo", updo, 0);
        chk("init_upack", upack, 0);
        #2 rst_n = 1'b1;

        // Enable mask, raise an event, read pending status.
        access(1'b1, 2'd0, 8'h05);
        stky = 8'h04;
        cycle();
        chk("irq_lat1", irq, 0);
        cycle();
        chk("irq_lat2", irq, 1);
        access(1'b0, 2'd2, 8'h00);
        chk("pend_rd", updo, 8'h04);
        chk("pend_ack", upack, 1);

        // Holdoff of 3, then a new event during HOLD.
        access(1'b1, 2'd1, 8'd3);
        stky = 8'h00;
        cycle();
        stky = 8'h01;
        n = 0;
        while (n < 20) begin
            cycle();
            if (irq) break;
            n++;
        end
        chk("hold_low_cycles", n, 4);

        // Mask cleared while asserted.
        stky = 8'hFF;
        cycle();
        cycle();
        access(1'b1, 2'd0, 8'h00);
        cycle();
        cycle();
        chk("mask_clr_irq", irq, 0);
        access(1'b0, 2'd2, 8'h00);
        chk("pend_masked", updo, 8'h00);

        // Reset in the middle of HOLD.
        access(1'b1, 2'd0, 8'h05);
        stky = 8'h04;
        repeat (3) cycle();
        stky = 8'h00;
        cycle();
        access(1'b0, 2'd0, 8'h00);
        chk("pre_rst_updo", updo, 8'h05);
        async_reset();
        access(1'b0, 2'd0, 8'h00);
        chk("post_rst_mask", updo, 8'h00);
        access(1'b0, 2'd1, 8'h00);
        chk("post_rst_hold", updo, 8'h00);

        // Read-only and reserved addresses.
        access(1'b1, 2'd0, 8'h0F);
        access(1'b1, 2'd1, 8'd2);
        access(1'b1, 2'd2, 8'hFF);
        chk("wr2_ack", upack, 1);
        access(1'b0, 2'd3, 8'h00);
        chk("rd3_val", updo, 8'h00);
        chk("rd3_ack", upack, 1);
        access(1'b0, 2'd0, 8'h00);
        chk("mask_kept", updo, 8'h0F);
        access(1'b0, 2'd1, 8'h00);
        chk("hold_kept", updo, 8'h02);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) stky = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                logic [1:0] a;
                logic [7:0] d;
                a = 2'($urandom_range(0, 3));
                d = (a == 2'd1) ? 8'($urandom_range(0, 6)) : 8'($urandom);
                access(1'($urandom_range(0, 1)), a, d);
            end else begin
                cycle();
            end
        end

`ifdef INTRX_PULSE_EN
        async_reset();
        stky = 8'h00;
        access(1'b1, 2'd0, 8'h01);
        stky = 8'h01;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (irq) n++;
        end
        chk("pulse_width", n, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
